lifelike_cell: RTL and testbench



---
 rtl/lifelike_pkg.sv | 17 +
 rtl/lifelike_cell_popcount.sv | 20 ++
 rtl/lifelike_cell.sv | 111 +++++++++++
 tb/tb_lifelike_cell.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifelike_pkg.sv
// Shared constants and helpers for the Life-like "Generations" cell family.
package lifelike_pkg;

  // Phase encoding: 0 is dead, 1 is alive, and values 2..C-1 are dying.
  localparam int unsigned PHASE_DEAD  = 0;
  localparam int unsigned PHASE_ALIVE = 1;

  // Classic Conway rule masks. Bit k corresponds to k live neighbours.
  localparam logic [8:0] B3_MASK  = 9'b000001000;
  localparam logic [8:0] S23_MASK = 9'b000001100;

  // Width needed to hold a count from 0 to n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lifelike_cell_popcount.sv
// Purely combinational count of set bits in a neighbour vector.
module neighbor_popcount
  import lifelike_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned CW = count_width(N)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  // Add up the set bits in the neighbour vector.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/lifelike_cell.sv
// One cell of a Life-like Generations automaton with a run-time loadable
// birth/survive rule, decay states, a saturating age counter and event pulses.
module lifelike_cell
  import lifelike_pkg::*;
#(
  parameter  int unsigned            N_NEIGHBORS     = 8,
  parameter  int unsigned            N_STATES        = 2,
  parameter  int unsigned            AGE_W           = 8,
  parameter  logic [N_NEIGHBORS:0]   DEFAULT_BIRTH   = B3_MASK,
  parameter  logic [N_NEIGHBORS:0]   DEFAULT_SURVIVE = S23_MASK,
  localparam int unsigned            PW = (N_STATES > 2) ? $clog2(N_STATES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     state_0,
  input  logic [N_NEIGHBORS-1:0]   neighbors,
  input  logic                     rule_load,
  input  logic [N_NEIGHBORS:0]     birth_mask,
  input  logic [N_NEIGHBORS:0]     survive_mask,
  output logic                     state_d,
  output logic                     state_q,
  output logic [PW-1:0]            phase_q,
  output logic [AGE_W-1:0]         age_q,
  output logic                     born,
  output logic                     died
);

  localparam int unsigned CW = count_width(N_NEIGHBORS);

  localparam logic [PW-1:0] P_DEAD  = PW'(PHASE_DEAD);
  localparam logic [PW-1:0] P_ALIVE = PW'(PHASE_ALIVE);
  localparam logic [PW-1:0] P_LAST  = PW'(N_STATES - 1);
  // First phase after losing survival: straight to dead in classic Life.
  localparam logic [PW-1:0] P_DYING = (N_STATES > 2) ? PW'(2) : PW'(PHASE_DEAD);

  logic [CW-1:0]          count;
  logic [PW-1:0]          next_phase;
  logic [PW-1:0]          phase_d;
  logic [AGE_W-1:0]       age_d;
  logic                   born_q, born_d;
  logic                   died_q, died_d;
  logic [N_NEIGHBORS:0]   birth_q, birth_d;
  logic [N_NEIGHBORS:0]   survive_q, survive_d;

  neighbor_popcount #(.N(N_NEIGHBORS)) u_popcount (
    .bits  (neighbors),
    .count (count)
  );

  // Next-phase function from the current phase, neighbour count and rules.
  always_comb begin
    next_phase = P_DEAD;
    if (phase_q == P_DEAD) begin
      if (birth_q[count]) next_phase = P_ALIVE;
    end else if (phase_q == P_ALIVE) begin
      next_phase = survive_q[count] ? P_ALIVE : P_DYING;
    end else if (phase_q != P_LAST) begin
      next_phase = phase_q + 1'b1;
    end
  end

  // Step, age, event and rule-capture next values.
  always_comb begin
    phase_d   = phase_q;
    age_d     = age_q;
    born_d    = 1'b0;
    died_d    = 1'b0;
    birth_d   = birth_q;
    survive_d = survive_q;
    if (ena) begin
      phase_d = next_phase;
      born_d  = (phase_q == P_DEAD)  && (next_phase == P_ALIVE);
      died_d  = (phase_q == P_ALIVE) && (next_phase != P_ALIVE);
      if ((phase_q == P_ALIVE) && (next_phase == P_ALIVE)) begin
        age_d = (age_q == '1) ? age_q : age_q + 1'b1;
      end else begin
        age_d = '0;
      end
    end
    if (rule_load) begin
      birth_d   = birth_mask;
      survive_d = survive_mask;
    end
  end

  // State registers; reset overrides any step or rule load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= state_0 ? P_ALIVE : P_DEAD;
      age_q     <= '0;
      born_q    <= 1'b0;
      died_q    <= 1'b0;
      birth_q   <= DEFAULT_BIRTH;
      survive_q <= DEFAULT_SURVIVE;
    end else begin
      phase_q   <= phase_d;
      age_q     <= age_d;
      born_q    <= born_d;
      died_q    <= died_d;
      birth_q   <= birth_d;
      survive_q <= survive_d;
    end
  end

  assign state_d = (next_phase == P_ALIVE);
  assign state_q = (phase_q == P_ALIVE);
  assign born    = born_q;
  assign died    = died_q;

endmodule

// File: tb/tb_lifelike_cell.sv
// Bench for lifelike_cell: three configurations (classic, C=4, AGE_W=3) share
// the same stimulus; directed scenarios plus a randomized run against a model.
module tb_lifelike_cell;

  logic       clk = 1'b0;
  logic       rst = 1'b1, ena = 1'b0, state_0 = 1'b0, rule_load = 1'b0;
  logic [7:0] neighbors = '0;
  logic [8:0] birth_mask = '0, survive_mask = '0;

  always #5 clk = ~clk;

  logic       sd [3];
  logic       sq [3];
  logic       bn [3];
  logic       dd [3];
  logic [0:0] ph0, ph2;
  logic [1:0] ph1;
  logic [7:0] ag0, ag1;
  logic [2:0] ag2;
  logic [7:0] dph [3];
  logic [7:0] dag [3];

  assign dph[0] = {7'b0, ph0};
  assign dph[1] = {6'b0, ph1};
  assign dph[2] = {7'b0, ph2};
  assign dag[0] = ag0;
  assign dag[1] = ag1;
  assign dag[2] = {5'b0, ag2};

  lifelike_cell dut0 (
    .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
    .rule_load(rule_load), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .state_d(sd[0]), .state_q(sq[0]), .phase_q(ph0), .age_q(ag0),
    .born(bn[0]), .died(dd[0]));

  lifelike_cell #(.N_STATES(4)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
    .rule_load(rule_load), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .state_d(sd[1]), .state_q(sq[1]), .phase_q(ph1), .age_q(ag1),
    .born(bn[1]), .died(dd[1]));

  lifelike_cell #(.AGE_W(3)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .state_0(state_0), .neighbors(neighbors),
    .rule_load(rule_load), .birth_mask(birth_mask), .survive_mask(survive_mask),
    .state_d(sd[2]), .state_q(sq[2]), .phase_q(ph2), .age_q(ag2),
    .born(bn[2]), .died(dd[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: Generations rule applied to each configuration.
  localparam int MC   [3] = '{2, 4, 2};
  localparam int MAXA [3] = '{255, 255, 7};
  int         m_phase [3];
  int         m_age   [3];
  bit         m_born  [3];
  bit         m_died  [3];
  logic [8:0] m_b     [3];
  logic [8:0] m_s     [3];

  function automatic int mnext(input int c, input int ph, input int cnt,
                               input logic [8:0] b, input logic [8:0] s);
    if (ph == 0) return b[cnt] ? 1 : 0;
    if (ph == 1) return s[cnt] ? 1 : ((c == 2) ? 0 : 2);
    return (ph + 1) % c;
  endfunction

  function automatic int mnx(input int k);
    return mnext(MC[k], m_phase[k], $countones(neighbors), m_b[k], m_s[k]);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_phase[k] <= state_0 ? 1 : 0;
        m_age[k]   <= 0;
        m_born[k]  <= 1'b0;
        m_died[k]  <= 1'b0;
        m_b[k]     <= 9'b000001000;
        m_s[k]     <= 9'b000001100;
      end else begin
        if (ena) begin
          m_phase[k] <= mnx(k);
          m_born[k]  <= (m_phase[k] == 0) && (mnx(k) == 1);
          m_died[k]  <= (m_phase[k] == 1) && (mnx(k) != 1);
          m_age[k]   <= ((m_phase[k] == 1) && (mnx(k) == 1))
                        ? ((m_age[k] < MAXA[k]) ? m_age[k] + 1 : m_age[k]) : 0;
        end else begin
          m_born[k] <= 1'b0;
          m_died[k] <= 1'b0;
        end
        if (rule_load) begin
          m_b[k] <= birth_mask;
          m_s[k] <= survive_mask;
        end
      end
    end
  end

  // Drive one cycle of inputs on the falling edge; return 1 time unit later.
  task automatic cyc(input logic r, input logic e, input logic s0,
                     input logic [7:0] nb, input logic rl = 1'b0,
                     input logic [8:0] bm = 9'd0, input logic [8:0] sm = 9'd0);
    @(negedge clk);
    rst = r; ena = e; state_0 = s0; neighbors = nb;
    rule_load = rl; birth_mask = bm; survive_mask = sm;
    #1;
  endtask

  task automatic test_reset;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (dph[k] !== 8'd0 || dag[k] !== 8'd0 || bn[k] !== 1'b0 || dd[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_dead k=%0d got ph=%0h age=%0h b=%b d=%b want 0 0 0 0",
                 k, dph[k], dag[k], bn[k], dd[k]);
      end
    end
    cyc(1, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (dph[k] !== 8'd1 || sq[k] !== 1'b1 || dag[k] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_alive k=%0d got ph=%0h sq=%b age=%0h want 1 1 0",
                 k, dph[k], sq[k], dag[k]);
      end
    end
  endtask

  task automatic test_classic;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h07);
    n_cmp++;
    if (sd[0] !== 1'b1) begin
      n_bad++; $display("FAIL classic_birth_d got %b want 1", sd[0]);
    end
    cyc(0, 1, 0, 8'h03);
    n_cmp++;
    if (sq[0] !== 1'b1 || bn[0] !== 1'b1 || dag[0] !== 8'd0 || sd[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL classic_born got sq=%b born=%b age=%0d sd=%b want 1 1 0 1",
               sq[0], bn[0], dag[0], sd[0]);
    end
    cyc(0, 1, 0, 8'h0F);
    n_cmp++;
    if (sq[0] !== 1'b1 || bn[0] !== 1'b0 || dag[0] !== 8'd1 || sd[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL classic_hold got sq=%b born=%b age=%0d sd=%b want 1 0 1 0",
               sq[0], bn[0], dag[0], sd[0]);
    end
    cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if (dd[0] !== 1'b1 || dph[0] !== 8'd0 || bn[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL classic_died got died=%b ph=%0d born=%b want 1 0 0",
               dd[0], dph[0], bn[0]);
    end
  endtask

  task automatic test_sweep;
    int cnt;
    logic exp_d;
    for (int v = 0; v < 256; v++) begin
      cnt = $countones(v[7:0]);
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 0, v[7:0]);
      exp_d = (cnt == 3);
      n_cmp++;
      if (sd[0] !== exp_d) begin
        n_bad++; $display("FAIL sweep_dead nb=%02h got %b want %b", v[7:0], sd[0], exp_d);
      end
      cyc(1, 0, 1, 8'h00);
      cyc(0, 0, 0, v[7:0]);
      exp_d = (cnt == 2) || (cnt == 3);
      n_cmp++;
      if (sd[0] !== exp_d) begin
        n_bad++; $display("FAIL sweep_alive nb=%02h got %b want %b", v[7:0], sd[0], exp_d);
      end
    end
  endtask

  task automatic test_decay;
    cyc(1, 0, 1, 8'h00);
    cyc(0, 1, 0, 8'h00);
    n_cmp++;
    if (sd[1] !== 1'b0 || dph[1] !== 8'd1) begin
      n_bad++; $display("FAIL decay_start got sd=%b ph=%0d want 0 1", sd[1], dph[1]);
    end
    cyc(0, 1, 0, 8'hFF);
    n_cmp++;
    if (dph[1] !== 8'd2 || dd[1] !== 1'b1 || sq[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL decay_p2 got ph=%0d died=%b sq=%b want 2 1 0", dph[1], dd[1], sq[1]);
    end
    cyc(0, 1, 0, 8'hFF);
    n_cmp++;
    if (dph[1] !== 8'd3 || dd[1] !== 1'b0 || sq[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL decay_p3 got ph=%0d died=%b sq=%b want 3 0 0", dph[1], dd[1], sq[1]);
    end
    cyc(0, 1, 0, 8'hFF);
    n_cmp++;
    if (dph[1] !== 8'd0 || dd[1] !== 1'b0 || bn[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL decay_p0 got ph=%0d died=%b born=%b want 0 0 0", dph[1], dd[1], bn[1]);
    end
  endtask

  task automatic test_rule_load;
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h3F, 1, 9'b001001000, 9'b000001100);
    n_cmp++;
    if (sd[0] !== 1'b0) begin
      n_bad++; $display("FAIL load_same_cycle got %b want 0", sd[0]);
    end
    cyc(0, 1, 0, 8'h3F);
    n_cmp++;
    if (sd[0] !== 1'b1 || sq[0] !== 1'b0 || bn[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL load_next_cycle got sd=%b sq=%b born=%b want 1 0 0", sd[0], sq[0], bn[0]);
    end
    cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if (bn[0] !== 1'b1 || sq[0] !== 1'b1) begin
      n_bad++; $display("FAIL load_born got born=%b sq=%b want 1 1", bn[0], sq[0]);
    end
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h3F);
    n_cmp++;
    if (sd[0] !== 1'b0) begin
      n_bad++; $display("FAIL load_revert got %b want 0", sd[0]);
    end
  endtask

  task automatic test_age;
    int want;
    cyc(1, 0, 1, 8'h00);
    cyc(0, 1, 0, 8'h03);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, (i < 10), 0, 8'h03);
      want = (i < 7) ? i : 7;
      n_cmp++;
      if (dag[2] !== 8'(want) || sq[2] !== 1'b1) begin
        n_bad++;
        $display("FAIL age_step i=%0d got age=%0d sq=%b want %0d 1", i, dag[2], sq[2], want);
      end
    end
    for (int j = 0; j < 3; j++) begin
      cyc(0, 0, 0, 8'h00);
      n_cmp++;
      if (dag[2] !== 8'd7 || bn[2] !== 1'b0 || dd[2] !== 1'b0 || dph[2] !== 8'd1) begin
        n_bad++;
        $display("FAIL age_hold j=%0d got age=%0d born=%b died=%b ph=%0d want 7 0 0 1",
                 j, dag[2], bn[2], dd[2], dph[2]);
      end
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 1, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 1, 8'h00);
    n_cmp++;
    if (dph[1] !== 8'd3) begin
      n_bad++; $display("FAIL mid_pre got ph=%0d want 3", dph[1]);
    end
    cyc(0, 0, 0, 8'h00);
    n_cmp++;
    if (dph[1] !== 8'd1 || dag[1] !== 8'd0 || bn[1] !== 1'b0 || dd[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset got ph=%0d age=%0d born=%b died=%b want 1 0 0 0",
               dph[1], dag[1], bn[1], dd[1]);
    end
    cyc(1, 0, 0, 8'h00, 1, 9'b001001000, 9'b111111111);
    cyc(0, 0, 0, 8'h3F);
    n_cmp++;
    if (sd[0] !== 1'b0) begin
      n_bad++; $display("FAIL rst_vs_load got %b want 0", sd[0]);
    end
  endtask

  task automatic test_random;
    logic r, e, rl;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 15) == 0);
      cyc(r, e, 1'($urandom), 8'($urandom), rl, 9'($urandom), 9'($urandom));
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (dph[k] !== 8'(m_phase[k]) || dag[k] !== 8'(m_age[k]) ||
            bn[k] !== m_born[k] || dd[k] !== m_died[k] ||
            sq[k] !== (m_phase[k] == 1) || sd[k] !== (mnx(k) == 1)) begin
          n_bad++;
          $display("FAIL random n=%0d k=%0d got ph=%0d age=%0d b=%b d=%b sq=%b sd=%b want ph=%0d age=%0d b=%b d=%b sq=%b sd=%b",
                   n, k, dph[k], dag[k], bn[k], dd[k], sq[k], sd[k],
                   m_phase[k], m_age[k], m_born[k], m_died[k],
                   (m_phase[k] == 1), (mnx(k) == 1));
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_classic;
    test_sweep;
    test_decay;
    test_rule_load;
    test_age;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
